// File: rtl/nf_cc_ahb_bridge.sv
// nf_cc_ahb_bridge
// Turns each CPU cross-connect request into a single non-pipelined AHB-Lite
// transfer (NONSEQ, SINGLE, word) and returns read data plus a one-cycle
// acknowledge. AHB error responses set a sticky bus_err flag.
//
// Optional feature: define NF_CC_AHB_TIMEOUT_EN to abort transfers whose
// hready stall reaches 2**TIMEOUT_W-1 cycles (completes with bus_err set).
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   addr_cc, wd_cc, we_cc  request address / write data / write enable
//   req_cc                 request, held by upstream until req_ack_cc
//   rd_cc                  registered read data, held until the next read
//   req_ack_cc             one-cycle completion pulse
//   haddr, hwrite, htrans  AHB address phase signals
//   hsize, hburst          constant word / SINGLE
//   hwdata                 AHB write data
//   hrdata, hready, hresp  AHB slave response
//   bus_err                sticky error flag, cleared only by reset
module nf_cc_ahb_bridge #(
   parameter int TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] addr_cc,
   output logic [31:0] rd_cc,
   input  logic [31:0] wd_cc,
   input  logic        we_cc,
   input  logic        req_cc,
   output logic        req_ack_cc,
   output logic [31:0] haddr,
   output logic        hwrite,
   output logic [1:0]  htrans,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [31:0] hwdata,
   input  logic [31:0] hrdata,
   input  logic        hready,
   input  logic        hresp,
   output logic        bus_err
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      ACK
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_r, wd_r;
   logic        we_r;
   logic        rd_upd;
   logic [31:0] rd_val;
   logic        err_set;
   logic        to_hit;

`ifdef NF_CC_AHB_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TO_ONE  = TIMEOUT_W'(1);
   // Compare against max-1: the stall that would bring the count to the
   // all-ones value is the one that aborts the transfer.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = {TIMEOUT_W{1'b1}} - TO_ONE;

   logic [TIMEOUT_W-1:0] to_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         to_cnt <= '0;
      end else if (state == IDLE && req_cc) begin
         to_cnt <= '0;
      end else if ((state == ADDR || state == DATA) && !hready) begin
         to_cnt <= to_cnt + TO_ONE;
      end
   end

   assign to_hit = (state == ADDR || state == DATA) && !hready && (to_cnt == TO_LAST);
`else
   // No timeout: the bridge waits for hready forever. The term below is
   // constant-false and only keeps TIMEOUT_W referenced.
   assign to_hit = 1'b0 & (TIMEOUT_W > 0);
`endif

   // Address/data phase outputs come straight from the latched request.
   assign haddr  = addr_r;
   assign hwdata = wd_r;
   assign hsize  = 3'b010;
   assign hburst = 3'b000;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      htrans     = HTRANS_IDLE;
      hwrite     = 1'b0;
      req_ack_cc = 1'b0;
      rd_upd     = 1'b0;
      rd_val     = '0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (req_cc) state_nxt = ADDR;
         end
         ADDR: begin
            htrans = HTRANS_NONSEQ;
            hwrite = we_r;
            if (hready) begin
               state_nxt = DATA;
            end else if (to_hit) begin
               err_set   = 1'b1;
               rd_upd    = !we_r;
               state_nxt = ACK;
            end
         end
         DATA: begin
            hwrite = we_r;
            if (hready) begin
               err_set   = hresp;
               rd_upd    = !we_r;
               rd_val    = hresp ? 32'h0 : hrdata;
               state_nxt = ACK;
            end else if (to_hit) begin
               err_set   = 1'b1;
               rd_upd    = !we_r;
               state_nxt = ACK;
            end
         end
         ACK: begin
            req_ack_cc = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Upstream request is captured only in IDLE; later changes are ignored.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_r <= '0;
         wd_r   <= '0;
         we_r   <= 1'b0;
      end else if (state == IDLE && req_cc) begin
         addr_r <= addr_cc;
         wd_r   <= wd_cc;
         we_r   <= we_cc;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_cc <= '0;
      end else if (rd_upd) begin
         rd_cc <= rd_val;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_err <= 1'b0;
      end else if (err_set) begin
         bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nf_cc_ahb_bridge.sv
// Directed bench for nf_cc_ahb_bridge. A simple AHB slave is driven from the
// transfer task; expected read data is queued when a request is issued and
// popped when the acknowledge appears.
module tb_nf_cc_ahb_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] addr_cc, wd_cc, rd_cc;
   logic        we_cc, req_cc, req_ack_cc;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hready, hresp, bus_err;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [31:0] sb_q[$];
   logic [31:0] rd_model  = '0;
   logic        err_model = 1'b0;
   time         ns_time;
   int          ns_k;

   nf_cc_ahb_bridge #(.TIMEOUT_W(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .addr_cc   (addr_cc),
      .rd_cc     (rd_cc),
      .wd_cc     (wd_cc),
      .we_cc     (we_cc),
      .req_cc    (req_cc),
      .req_ack_cc(req_ack_cc),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .htrans    (htrans),
      .hsize     (hsize),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request. aw/dw: hready=0 cycles in address/data phase; hr: hresp
   // driven in data phase; exp_err: transfer is expected to end in error;
   // hold: keep req_cc high after the ack; exp_lat: negedges from drive to
   // ack (-1 = no ack expected within bound).
   task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [31:0] rdata, input int aw, input int dw,
                       input logic hr, input logic exp_err, input logic hold,
                       input int exp_lat, input int bound);
      int          k;
      logic        seen_ns, acked, hw_ok;
      logic [31:0] exp_rd;
      req_cc  = 1'b1;
      addr_cc = a;
      wd_cc   = wd;
      we_cc   = we;
      exp_rd  = we ? rd_model : (exp_err ? 32'h0 : rdata);
      if (exp_lat >= 0) begin
         rd_model = exp_rd;
         if (exp_err) err_model = 1'b1;
         sb_q.push_back(exp_rd);
      end
      k = 0; seen_ns = 1'b0; acked = 1'b0; hw_ok = 1'b1;
      while (!acked && k < bound) begin
         @(negedge clk);
         k++;
         if (req_ack_cc) begin
            acked = 1'b1;
         end else if (htrans == 2'b10) begin
            if (!seen_ns) begin
               seen_ns = 1'b1;
               ns_time = $time;
               ns_k    = k;
               chk({tag, ".haddr"}, haddr, a);
               chk({tag, ".hwrite"}, {31'b0, hwrite}, {31'b0, we});
            end
            if (hwdata !== wd) hw_ok = 1'b0;
            hresp  = 1'b0;
            hready = (aw == 0);
            if (aw > 0) aw--;
         end else if (seen_ns) begin
            if (hwdata !== wd || hwrite !== we || haddr !== a || htrans !== 2'b00) hw_ok = 1'b0;
            hrdata = rdata;
            hresp  = hr;
            hready = (dw == 0);
            if (dw > 0) dw--;
         end
      end
      if (exp_lat >= 0) begin
         chk({tag, ".ack_seen"}, {31'b0, acked}, 32'd1);
         if (acked) begin
            chk({tag, ".ack_lat"}, k, exp_lat);
            chk({tag, ".rd_cc"}, rd_cc, sb_q.pop_front());
            chk({tag, ".bus_err"}, {31'b0, bus_err}, {31'b0, err_model});
            chk({tag, ".hwdata_hold"}, {31'b0, hw_ok}, 32'd1);
         end
      end else begin
         chk({tag, ".no_ack"}, {31'b0, acked}, 32'd0);
      end
      hready = 1'b1;
      hresp  = 1'b0;
      if (!hold) req_cc = 1'b0;
   endtask

   initial begin
      time t1;
      resetn = 1'b0;
      req_cc = 1'b0; addr_cc = '0; wd_cc = '0; we_cc = 1'b0;
      hrdata = '0; hready = 1'b1; hresp = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst.htrans", {30'b0, htrans}, 32'd0);
      chk("rst.hsize", {29'b0, hsize}, 32'd2);
      chk("rst.hburst", {29'b0, hburst}, 32'd0);
      chk("rst.req_ack", {31'b0, req_ack_cc}, 32'd0);
      chk("rst.rd_cc", rd_cc, 32'h0);
      chk("rst.bus_err", {31'b0, bus_err}, 32'd0);
      chk("rst.haddr", haddr, 32'h0);
      chk("rst.hwrite", {31'b0, hwrite}, 32'd0);
      chk("rst.hwdata", hwdata, 32'h0);
      resetn = 1'b1;
      @(negedge clk);

      // Zero-wait read
      xfer("rd0", 32'h0000_0100, 32'h0, 1'b0, 32'hA5A5_1234, 0, 0, 1'b0, 1'b0, 1'b0, 3, 50);
      chk("rd0.ns_cycle", ns_k, 32'd1);
      @(negedge clk);
      chk("rd0.ack_pulse", {31'b0, req_ack_cc}, 32'd0);
      chk("rd0.htrans_idle", {30'b0, htrans}, 32'd0);

      // Write with two data-phase wait states
      xfer("wr2", 32'h0001_0000, 32'hCAFE_0001, 1'b1, 32'h5555_5555, 0, 2, 1'b0, 1'b0, 1'b0, 5, 50);
      @(negedge clk);

      // Back-to-back reads with req_cc held across the ack
      xfer("b2b0", 32'h0000_0010, 32'h0, 1'b0, 32'h1111_0010, 0, 0, 1'b0, 1'b0, 1'b1, 3, 50);
      t1 = ns_time;
      xfer("b2b1", 32'h0000_0014, 32'h0, 1'b0, 32'h2222_0014, 0, 0, 1'b0, 1'b0, 1'b0, 4, 50);
      chk("b2b.ns_gap", 32'(ns_time - t1), 32'd40);
      @(negedge clk);

      // Two-cycle error response on a read, with an address wait state too
      xfer("err", 32'h0000_0200, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 1, 1'b1, 1'b1, 1'b0, 5, 50);
      @(negedge clk);
      chk("err.ack_once", {31'b0, req_ack_cc}, 32'd0);

      // Good read afterwards: bus_err stays set
      xfer("post_err", 32'h0000_0300, 32'h0, 1'b0, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b0, 1'b0, 3, 50);
      @(negedge clk);

      // Reset asserted during DATA
      req_cc = 1'b1; addr_cc = 32'h0000_0400; we_cc = 1'b0;
      @(negedge clk);
      hready = 1'b1;
      @(negedge clk);
      hready = 1'b0;
      #2 resetn = 1'b0;
      req_cc = 1'b0;
      #1;
      chk("mrst.htrans", {30'b0, htrans}, 32'd0);
      chk("mrst.req_ack", {31'b0, req_ack_cc}, 32'd0);
      chk("mrst.rd_cc", rd_cc, 32'h0);
      chk("mrst.bus_err", {31'b0, bus_err}, 32'd0);
      @(negedge clk);
      hready = 1'b1;
      resetn = 1'b1;
      rd_model  = '0;
      err_model = 1'b0;
      @(negedge clk);
      chk("mrst.no_ack", {31'b0, req_ack_cc}, 32'd0);
      xfer("after_rst", 32'h0000_0500, 32'h0, 1'b0, 32'h1357_9BDF, 0, 0, 1'b0, 1'b0, 1'b0, 3, 50);
      @(negedge clk);

`ifdef NF_CC_AHB_TIMEOUT_EN
      // 15 data-phase stall cycles abort the read
      xfer("tmo", 32'h0000_0600, 32'h0, 1'b0, 32'hFFFF_0000, 0, 1000, 1'b0, 1'b1, 1'b0, 17, 60);
`else
      // Without the timeout the bridge keeps waiting
      xfer("no_tmo", 32'h0000_0600, 32'h0, 1'b0, 32'hFFFF_0000, 0, 1000, 1'b0, 1'b1, 1'b0, -1, 100);
      chk("no_tmo.bus_err", {31'b0, bus_err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nf_cc_ahb_bridge.md
# nf_cc_ahb_bridge

Single-master bridge that takes the CPU cross-connect request bus (addr/rd/wd/we/req/req_ack) and runs each request as one non-pipelined AHB-Lite single transfer toward the memory/peripheral interconnect. It sits directly downstream of the CPU cross-connect and returns read data and a one-cycle acknowledge to it. It also reports AHB error responses through a sticky status flag and, when configured, aborts stalled transfers by timeout.

## Interface
Parameters:
- TIMEOUT_W, default 8: width of the hready-stall counter. Used only with NF_CC_AHB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  reset resetn, asynchronous, active-low
- addr_cc  in  32  request address
- rd_cc  out  32  read data, registered, held until next completed read
- wd_cc  in  32  write data
- we_cc  in  1  write enable (1 = write)
- req_cc  in  1  request, held by upstream until req_ack_cc seen
- req_ack_cc  out  1  one-cycle completion pulse
- haddr  out  32  AHB address
- hwrite  out  1  AHB write
- htrans  out  2  AHB transfer type (IDLE 2'b00 / NONSEQ 2'b10 only)
- hsize  out  3  constant 3'b010 (word)
- hburst  out  3  constant 3'b000 (SINGLE)
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB error response
- bus_err  out  1  sticky error flag

## Operation
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE: htrans=IDLE. If req_cc=1: latch addr_cc, wd_cc, we_cc into addr_r, wd_r, we_r; go ADDR. Otherwise stay.
- ADDR: htrans=NONSEQ, haddr=addr_r, hwrite=we_r, hwdata=wd_r. If hready=1, go DATA; else stay.
- DATA: htrans=IDLE, haddr and hwrite held, hwdata=wd_r.
  - If hready=1 and hresp=0: on a read, rd_cc <= hrdata; go ACK.
  - If hready=1 and hresp=1: set bus_err; on a read, rd_cc <= 0; go ACK.
  - If hready=0: stay.
- ACK: req_ack_cc=1 for exactly this cycle, htrans=IDLE; go IDLE.
- Upstream inputs are sampled only in IDLE. Changes to req_cc, addr_cc, wd_cc or we_cc during ADDR, DATA or ACK are ignored.
- In the IDLE cycle that follows ACK, req_cc=1 is treated as a new request. Back-to-back requests are therefore legal.
- A write leaves rd_cc unchanged.
- bus_err is cleared only by reset.

## Timing
- Reset values: all outputs 0, except hsize=3'b010 and hburst=3'b000 (constants). FSM resets to IDLE. addr_r, wd_r and we_r reset to 0.
- Assertion of resetn mid-transfer: the FSM returns to IDLE immediately and htrans=IDLE. No ack is issued for the aborted request.
- Latency with zero wait states: req_cc sampled high in cycle 0 (IDLE), ADDR in cycle 1, DATA in cycle 2, req_ack_cc high in cycle 3.
- Each hready=0 cycle in ADDR or DATA adds one cycle of latency.
- Minimum request-to-request period is 4 cycles.
- hwdata is valid from the ADDR cycle through the end of DATA.
- rd_cc becomes valid in the ACK cycle.
- A two-cycle AHB error (hresp=1 with hready=0, then hresp=1 with hready=1) completes on the second cycle. bus_err reads 1 from the ACK cycle onward.

## Configuration
- NF_CC_AHB_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter clears on entry to ADDR and increments on every hready=0 cycle in ADDR or DATA.
  - When the counter reaches 2**TIMEOUT_W-1 while hready=0, the FSM goes to ACK, sets bus_err and, for a read, sets rd_cc <= 0. htrans=IDLE thereafter.
- Not defined: the counter does not exist, the FSM waits indefinitely for hready, and TIMEOUT_W has no effect.

## Test plan
- Read with zero wait states: req_cc=1, addr_cc=32'h0000_0100, we_cc=0, slave hrdata=32'hA5A5_1234 -> htrans=NONSEQ in cycle 1, req_ack_cc in cycle 3, rd_cc=32'hA5A5_1234, bus_err=0.
- Write with 2 DATA wait states: addr_cc=32'h0001_0000, wd_cc=32'hCAFE_0001, we_cc=1 -> hwrite=1, hwdata=32'hCAFE_0001 through DATA, req_ack_cc in cycle 5, rd_cc unchanged.
- Back-to-back requests: read 32'h10 then read 32'h14 with req_cc held high across the ack -> second NONSEQ appears 4 cycles after the first, two acks, each rd_cc correct.
- Error response: hresp=1/hready=0, then hresp=1/hready=1 on a read -> req_ack_cc pulses once, rd_cc=0, bus_err=1 and stays 1 through later good transfers until resetn=0.
- Reset mid-transfer: deassert resetn during DATA -> htrans=0, req_ack_cc=0, rd_cc=0, bus_err=0; the next request after reset completes normally.
- Timeout with macro defined and TIMEOUT_W=4: hready held 0 in DATA -> ack after 15 stall cycles, bus_err=1, rd_cc=0. Without the macro, no ack occurs after 100 cycles.
